// File: rtl/barrel_run_ctl.sv
// Run controller for one barrel core: sequences core reset, counts run cycles
// until halt or budget expiry, then quiesces the core and holds the result for the host.
module barrel_run_ctl #(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic             core_halt,
  output logic             core_resetn,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycles,
  output logic [1:0]       fsm_state
);

  // Host handshake: start is a single-cycle request honoured only in IDLE.
  // done is a level that stays high (with cycles/timed_out stable) until the
  // host returns ack; ack is honoured only in DONE and wins over start there.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  if (MAX_CYCLES < 1 || MAX_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_max
    $error("barrel_run_ctl: MAX_CYCLES must be in 1..2^CNT_W-1");
  end
  if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_rst
    $error("barrel_run_ctl: RESET_CYCLES must be in 1..255");
  end

  localparam logic [7:0]       HOLD_LOAD = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);

  state_t           state, state_nx;
  logic [7:0]       hold_cnt, hold_nx;
  logic [CNT_W-1:0] cycles_nx;
  logic             timed_out_nx;

  always_comb begin
    state_nx     = state;
    hold_nx      = hold_cnt;
    cycles_nx    = cycles;
    timed_out_nx = timed_out;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx     = S_HOLD;
          hold_nx      = HOLD_LOAD;
          cycles_nx    = '0;
          timed_out_nx = 1'b0;
        end
      end
      S_HOLD: begin
        // Loaded with RESET_CYCLES-1 so the core sees exactly RESET_CYCLES low cycles.
        if (hold_cnt == 8'd0) begin
          state_nx = S_RUN;
        end else begin
          hold_nx = hold_cnt - 8'd1;
        end
      end
      S_RUN: begin
        if (core_halt) begin
          state_nx     = S_DONE;
          timed_out_nx = 1'b0;
        end else if (cycles == LAST_CNT) begin
          state_nx     = S_DONE;
          cycles_nx    = MAX_CNT;
          timed_out_nx = 1'b1;
        end else begin
          cycles_nx = cycles + 1'b1;
        end
      end
      S_DONE: begin
        if (ack) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      cycles      <= '0;
      timed_out   <= 1'b0;
      core_resetn <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      cycles      <= cycles_nx;
      timed_out   <= timed_out_nx;
      core_resetn <= (state_nx == S_RUN);
      busy        <= (state_nx == S_HOLD) || (state_nx == S_RUN);
      done        <= (state_nx == S_DONE);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_barrel_run_ctl.sv
// Directed testbench for barrel_run_ctl: reset, halt, timeout, early halt,
// handshake robustness and mid-run reset, with a MAX_CYCLES=1 side instance.
module tb_barrel_run_ctl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, start, ack, core_halt;
  logic core_resetn, busy, done, timed_out;
  logic [15:0] cycles;
  logic [1:0]  fsm_state;

  logic start2, ack2, halt2;
  logic core_resetn2, busy2, done2, timed_out2;
  logic [15:0] cycles2;
  logic [1:0]  fsm_state2;

  always #5 clk = ~clk;

  barrel_run_ctl #(.RESET_CYCLES(2), .MAX_CYCLES(1000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .core_halt(core_halt),
    .core_resetn(core_resetn), .busy(busy), .done(done), .timed_out(timed_out),
    .cycles(cycles), .fsm_state(fsm_state)
  );

  barrel_run_ctl #(.RESET_CYCLES(2), .MAX_CYCLES(1), .CNT_W(16)) dut_min (
    .clk(clk), .reset(reset), .start(start2), .ack(ack2), .core_halt(halt2),
    .core_resetn(core_resetn2), .busy(busy2), .done(done2), .timed_out(timed_out2),
    .cycles(cycles2), .fsm_state(fsm_state2)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".resetn"}, 32'(core_resetn), 32'd0);
    check({tag, ".busy"},   32'(busy),        32'd0);
    check({tag, ".done"},   32'(done),        32'd0);
    check({tag, ".to"},     32'(timed_out),   32'd0);
    check({tag, ".cycles"}, 32'(cycles),      32'd0);
  endtask

  // Start pulse (optionally held through HOLD) and walk the 2-cycle hold window.
  task automatic do_start(input string tag, input bit keep_start);
    start = 1'b1;
    tick();
    if (!keep_start) start = 1'b0;
    check({tag, ".hold1_state"},  32'(fsm_state),   32'(ST_HOLD));
    check({tag, ".hold1_resetn"}, 32'(core_resetn), 32'd0);
    check({tag, ".hold1_busy"},   32'(busy),        32'd1);
    tick();
    check({tag, ".hold2_resetn"}, 32'(core_resetn), 32'd0);
    tick();
    start = 1'b0;
    check({tag, ".run_resetn"},   32'(core_resetn), 32'd1);
    check({tag, ".run_state"},    32'(fsm_state),   32'(ST_RUN));
  endtask

  // Compare a finished run against the next expected cycle count.
  task automatic expect_done(input string tag, input logic exp_to);
    logic [15:0] exp_c;
    exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    check({tag, ".done"},   32'(done),        32'd1);
    check({tag, ".busy"},   32'(busy),        32'd0);
    check({tag, ".resetn"}, 32'(core_resetn), 32'd0);
    check({tag, ".to"},     32'(timed_out),   32'(exp_to));
    check({tag, ".cycles"}, 32'(cycles),      32'(exp_c));
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, ".ack_done"},  32'(done),      32'd0);
    check({tag, ".ack_state"}, 32'(fsm_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    reset = 1'b1; start = 1'b0; ack = 1'b0; core_halt = 1'b0;
    start2 = 1'b0; ack2 = 1'b0; halt2 = 1'b0;

    // 1. reset with start and halt asserted
    start = 1'b1; core_halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_zero("rst");
      check("rst.state", 32'(fsm_state), 32'(ST_IDLE));
    end
    reset = 1'b0; start = 1'b0; core_halt = 1'b0;
    tick();
    check_idle_zero("rst_rel");

    // 2. normal halt after 5 run cycles
    exp_q.push_back(16'd5);
    do_start("halt", 1'b0);
    repeat (5) tick();
    check("halt.run5_cycles", 32'(cycles), 32'd5);
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    expect_done("halt", 1'b0);
    repeat (3) tick();
    check("halt.held_done",   32'(done),   32'd1);
    check("halt.held_cycles", 32'(cycles), 32'd5);
    do_ack("halt");
    check("halt.idle_cycles", 32'(cycles), 32'd5);

    // 3. timeout at 1000 run cycles
    exp_q.push_back(16'd1000);
    do_start("tmo", 1'b0);
    waited = 0;
    while (!done && waited < 1100) begin
      tick();
      waited++;
    end
    check("tmo.run_edges", 32'(waited), 32'd1000);
    expect_done("tmo", 1'b1);
    do_ack("tmo");

    // 3b. MAX_CYCLES=1: done on the first RUN edge
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    check("min.run_resetn", 32'(core_resetn2), 32'd1);
    tick();
    check("min.done",   32'(done2),       32'd1);
    check("min.to",     32'(timed_out2),  32'd1);
    check("min.cycles", 32'(cycles2),     32'd1);
    check("min.resetn", 32'(core_resetn2), 32'd0);
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    check("min.ack_done", 32'(done2), 32'd0);

    // 4. halt high throughout: hold still 2 cycles, halt in first RUN cycle
    exp_q.push_back(16'd0);
    core_halt = 1'b1;
    do_start("early", 1'b0);
    tick();
    core_halt = 1'b0;
    expect_done("early", 1'b0);
    do_ack("early");

    // 5. handshake robustness
    exp_q.push_back(16'd3);
    do_start("hs", 1'b1);
    start = 1'b1;
    repeat (3) tick();
    check("hs.run_state",  32'(fsm_state), 32'(ST_RUN));
    check("hs.run_cycles", 32'(cycles),    32'd3);
    start = 1'b0;
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    expect_done("hs", 1'b0);
    start = 1'b1;
    repeat (2) tick();
    check("hs.done_start_state",  32'(fsm_state), 32'(ST_DONE));
    check("hs.done_start_cycles", 32'(cycles),    32'd3);
    ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    check("hs.sa_state",  32'(fsm_state),   32'(ST_IDLE));
    check("hs.sa_resetn", 32'(core_resetn), 32'd0);
    check("hs.sa_busy",   32'(busy),        32'd0);
    tick();
    check("hs.sa_norun", 32'(fsm_state), 32'(ST_IDLE));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("hs.idle_ack_state",  32'(fsm_state), 32'(ST_IDLE));
    check("hs.idle_ack_done",   32'(done),      32'd0);
    check("hs.idle_ack_cycles", 32'(cycles),    32'd3);

    // 6. reset at RUN cycle 400, then a clean run
    do_start("mid", 1'b0);
    repeat (400) tick();
    check("mid.cycles400", 32'(cycles), 32'd400);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_zero("mid_rst");
    check("mid_rst.state", 32'(fsm_state), 32'(ST_IDLE));
    exp_q.push_back(16'd7);
    do_start("after", 1'b0);
    check("after.cycles0", 32'(cycles), 32'd0);
    repeat (7) tick();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    expect_done("after", 1'b0);
    do_ack("after");

    check("sb.empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
